e_alloc: RTL and testbench

E_ALLOC -- requirements
Module: e_alloc

---
 rtl/e_pkg.sv | 19 +
 rtl/e_cell.sv | 34 +++
 rtl/e_alloc.sv | 157 +++++++++++++++
 tb/tb_e_alloc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_pkg.sv
// Shared definitions for the e_alloc slot allocator: FSM states, width limits
// and a one-hot helper.
package e_pkg;

   localparam int W_MIN = 2;
   localparam int W_MAX = 8;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [W_MAX-1:0] v);
      return (v != {W_MAX{1'b0}}) &&
             ((v & (v - {{(W_MAX-1){1'b0}}, 1'b1})) == {W_MAX{1'b0}});
   endfunction

endpackage

// File: rtl/e_cell.sv
// Priority search cell: returns the highest clear busy bit, restricted to bits
// strictly below ptr unless force_msb requests a full scan from the MSB.
module e_cell
   import e_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] busy,
   input  logic [W-1:0] ptr,
   input  logic         force_msb,
   output logic         vld,
   output logic [W-1:0] id
);

   logic [W-1:0] free_s;
   logic         hi_s;

   // Highest-set-bit isolation over the eligible free slots.
   always_comb begin
      if (force_msb) begin
         free_s = ~busy;
      end else begin
         free_s = ~busy & (ptr - {{(W-1){1'b0}}, 1'b1});
      end
      id   = {W{1'b0}};
      hi_s = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         id[i] = free_s[i] & ~hi_s;
         hi_s  = hi_s | free_s[i];
      end
      vld = hi_s;
   end

endmodule

// File: rtl/e_alloc.sv
// Round-robin slot allocator with drain handshake. Define E_ALLOC_ERR_EN to
// enable free-protocol checking and the sticky err_o flag.
module e_alloc
   import e_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         alloc_req_i,
   output logic         alloc_vld_o,
   output logic [W-1:0] alloc_id_o,
   input  logic         free_vld_i,
   input  logic [W-1:0] free_id_i,
   input  logic         drain_req_i,
   output logic         drain_done_o,
   output logic [W-1:0] busy_o,
   output logic         full_o,
   output logic         empty_o,
   output logic         err_o
);

   generate
      if (W < W_MIN || W > W_MAX) begin : g_bad_w
         $error("e_alloc: W=%0d outside supported range", W);
      end
   endgenerate

   state_t       state_r, state_nxt_s;
   logic [W-1:0] busy_r, busy_nxt_s;
   logic [W-1:0] ptr_r, ptr_nxt_s;
   logic         drain_done_r, done_nxt_s;
   logic         below_vld_s, wrap_vld_s;
   logic [W-1:0] below_id_s, wrap_id_s, cand_s;
   logic         alloc_vld_s, grant_s;
   logic [W-1:0] free_mask_s;

   e_cell #(.W(W)) u_below (
      .busy(busy_r), .ptr(ptr_r), .force_msb(1'b0), .vld(below_vld_s), .id(below_id_s)
   );

   e_cell #(.W(W)) u_wrap (
      .busy(busy_r), .ptr(ptr_r), .force_msb(1'b1), .vld(wrap_vld_s), .id(wrap_id_s)
   );

   // Slots below the last grant take priority over the wrapped scan.
   always_comb begin
      if (below_vld_s) begin
         cand_s = below_id_s;
      end else begin
         cand_s = wrap_id_s;
      end
   end

   assign alloc_vld_s = (state_r == RUN) && (below_vld_s || wrap_vld_s);
   assign grant_s     = alloc_req_i && alloc_vld_s;

`ifdef E_ALLOC_ERR_EN
   logic [W_MAX-1:0] free_ext_s;
   logic             free_bad_s;
   logic             err_r;

   // A free must name exactly one currently busy slot; otherwise it is dropped.
   always_comb begin
      free_ext_s        = {W_MAX{1'b0}};
      free_ext_s[W-1:0] = free_id_i;
      free_bad_s = free_vld_i &&
                   (!is_onehot(free_ext_s) || ((free_id_i & busy_r) == {W{1'b0}}));
      if (free_vld_i && !free_bad_s) begin
         free_mask_s = free_id_i;
      end else begin
         free_mask_s = {W{1'b0}};
      end
   end

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_r <= 1'b0;
      end else if (free_bad_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign err_o = err_r;
`else
   // Unchecked free: every bit named is released.
   always_comb begin
      if (free_vld_i) begin
         free_mask_s = free_id_i;
      end else begin
         free_mask_s = {W{1'b0}};
      end
   end

   assign err_o = 1'b0;
`endif

   // Occupancy, pointer and drain FSM next-state.
   always_comb begin
      busy_nxt_s  = busy_r & ~free_mask_s;
      ptr_nxt_s   = ptr_r;
      state_nxt_s = state_r;
      done_nxt_s  = 1'b0;
      if (grant_s) begin
         busy_nxt_s = busy_nxt_s | cand_s;
         ptr_nxt_s  = cand_s;
      end else begin
         ptr_nxt_s = ptr_r;
      end
      case (state_r)
         RUN: begin
            if (drain_req_i) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (busy_r == {W{1'b0}}) begin
               state_nxt_s = RUN;
               done_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = RUN;
         end
      endcase
   end

   // State registers; pointer resets to bit 0 so the first grant wraps to the MSB.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_r      <= RUN;
         busy_r       <= {W{1'b0}};
         ptr_r        <= {{(W-1){1'b0}}, 1'b1};
         drain_done_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         busy_r       <= busy_nxt_s;
         ptr_r        <= ptr_nxt_s;
         drain_done_r <= done_nxt_s;
      end
   end

   assign alloc_vld_o  = alloc_vld_s;
   assign alloc_id_o   = cand_s;
   assign busy_o       = busy_r;
   assign full_o       = &busy_r;
   assign empty_o      = ~|busy_r;
   assign drain_done_o = drain_done_r;

endmodule

// File: tb/tb_e_alloc.sv
// Scoreboard bench for e_alloc (W=4): directed scenarios plus random traffic
// against an index-based reference model.
module tb_e_alloc;

   localparam int W = 4;

   logic         clk;
   logic         arst_n;
   logic         alloc_req_i;
   logic         alloc_vld_o;
   logic [W-1:0] alloc_id_o;
   logic         free_vld_i;
   logic [W-1:0] free_id_i;
   logic         drain_req_i;
   logic         drain_done_o;
   logic [W-1:0] busy_o;
   logic         full_o;
   logic         empty_o;
   logic         err_o;

   e_alloc #(.W(W)) dut (
      .clk(clk), .arst_n(arst_n),
      .alloc_req_i(alloc_req_i), .alloc_vld_o(alloc_vld_o), .alloc_id_o(alloc_id_o),
      .free_vld_i(free_vld_i), .free_id_i(free_id_i),
      .drain_req_i(drain_req_i), .drain_done_o(drain_done_o),
      .busy_o(busy_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic         vld;
      logic [W-1:0] id;
      logic [W-1:0] busy;
      logic         full;
      logic         empty;
      logic         done;
      logic         err;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // Reference model: slot occupancy by index, last granted index, drain mode.
   bit busy_m[W];
   int ptr_m;
   bit drain_m;
   bit done_m;
   bit err_m;

   function automatic void model_reset();
      for (int k = 0; k < W; k++) busy_m[k] = 1'b0;
      ptr_m   = 0;
      drain_m = 1'b0;
      done_m  = 1'b0;
      err_m   = 1'b0;
   endfunction

   function automatic int count_m();
      int c = 0;
      for (int k = 0; k < W; k++) c += busy_m[k];
      return c;
   endfunction

   function automatic int cand_m();
      for (int j = ptr_m - 1; j >= 0; j--) if (!busy_m[j]) return j;
      for (int j = W - 1; j >= 0; j--) if (!busy_m[j]) return j;
      return -1;
   endfunction

   function automatic void push_exp();
      exp_t e;
      int   c = cand_m();
      int   n = count_m();
      e.vld  = !drain_m && (n < W);
      e.id   = '0;
      if (c >= 0) e.id[c] = 1'b1;
      e.busy = '0;
      for (int k = 0; k < W; k++) e.busy[k] = busy_m[k];
      e.full  = (n == W);
      e.empty = (n == 0);
      e.done  = done_m;
      e.err   = err_m;
      q.push_back(e);
   endfunction

   function automatic void model_update(bit req, bit fv, logic [W-1:0] fid, bit dr);
      int n   = count_m();
      int c   = cand_m();
      bit vld = !drain_m && (n < W);
      int ones;
      int idx;
      done_m = drain_m && (n == 0);
      if (drain_m) drain_m = (n != 0);
      else         drain_m = dr;
      if (fv) begin
`ifdef E_ALLOC_ERR_EN
         ones = 0;
         idx  = 0;
         for (int k = 0; k < W; k++) if (fid[k]) begin ones++; idx = k; end
         if (ones != 1 || !busy_m[idx]) err_m = 1'b1;
         else busy_m[idx] = 1'b0;
`else
         ones = 0;
         idx  = 0;
         for (int k = 0; k < W; k++) if (fid[k]) busy_m[k] = 1'b0;
`endif
      end
      if (req && vld) begin
         busy_m[c] = 1'b1;
         ptr_m     = c;
      end
   endfunction

   task automatic step(input bit req, input bit fv, input logic [W-1:0] fid, input bit dr);
      @(posedge clk); #1;
      push_exp();
      alloc_req_i = req;
      free_vld_i  = fv;
      free_id_i   = fid;
      drain_req_i = dr;
      model_update(req, fv, fid, dr);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      arst_n      = 1'b0;
      alloc_req_i = 1'b0;
      free_vld_i  = 1'b0;
      free_id_i   = '0;
      drain_req_i = 1'b0;
      model_reset();
      push_exp();
      @(posedge clk); #1;
      push_exp();
      arst_n = 1'b1;
   endtask

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare every presented cycle against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("alloc_vld", {3'b000, alloc_vld_o}, {3'b000, e.vld});
         if (e.vld) chk("alloc_id", alloc_id_o, e.id);
         chk("busy", busy_o, e.busy);
         chk("full", {3'b000, full_o}, {3'b000, e.full});
         chk("empty", {3'b000, empty_o}, {3'b000, e.empty});
         chk("drain_done", {3'b000, drain_done_o}, {3'b000, e.done});
         chk("err", {3'b000, err_o}, {3'b000, e.err});
      end
   end

   initial begin
      logic [W-1:0] fid;
      int           k;
      arst_n      = 1'b0;
      alloc_req_i = 1'b0;
      free_vld_i  = 1'b0;
      free_id_i   = '0;
      drain_req_i = 1'b0;
      model_reset();

      // Fill from reset, then free under full with requests held.
      do_reset();
      repeat (5) step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b1, 4'b0100, 1'b0);
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b0, 4'b0000, 1'b0);

      // Below-pointer search and wrap.
      do_reset();
      repeat (4) step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b1, 4'b0100, 1'b0);
      step(1'b0, 1'b1, 4'b0001, 1'b0);
      step(1'b0, 1'b1, 4'b1000, 1'b0);
      repeat (3) step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b1, 4'b1000, 1'b0);
      step(1'b0, 1'b1, 4'b0100, 1'b0);
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b0, 4'b0000, 1'b0);

      // Simultaneous grant and free.
      do_reset();
      repeat (4) step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b1, 4'b1000, 1'b0);
      step(1'b0, 1'b1, 4'b0100, 1'b0);
      step(1'b0, 1'b1, 4'b0010, 1'b0);
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b1, 4'b0001, 1'b0);
      step(1'b0, 1'b0, 4'b0000, 1'b0);

      // Drain with slots outstanding, repeated drain request ignored.
      do_reset();
      repeat (3) step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b1, 4'b1000, 1'b0);
      step(1'b1, 1'b0, 4'b0000, 1'b1);
      step(1'b1, 1'b0, 4'b0000, 1'b1);
      step(1'b1, 1'b1, 4'b0100, 1'b0);
      step(1'b1, 1'b1, 4'b0010, 1'b0);
      repeat (4) step(1'b1, 1'b0, 4'b0000, 1'b0);

      // Drain when already empty, then reset in the middle of a drain.
      do_reset();
      step(1'b0, 1'b0, 4'b0000, 1'b1);
      repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b0, 4'b0000, 1'b1);
      step(1'b0, 1'b0, 4'b0000, 1'b0);
      do_reset();
      repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0);

`ifdef E_ALLOC_ERR_EN
      // Bad frees on an empty allocator.
      do_reset();
      step(1'b0, 1'b1, 4'b0011, 1'b0);
      repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0);
      do_reset();
      step(1'b0, 1'b1, 4'b1000, 1'b0);
      repeat (3) step(1'b1, 1'b0, 4'b0000, 1'b0);
`endif

      // Random traffic, mostly legal frees, occasional drain and reset.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            fid = '0;
            if ($urandom_range(0, 9) < 8) begin
               k = $urandom_range(0, W - 1);
               if (busy_m[k]) fid[k] = 1'b1;
            end else begin
               fid = 4'($urandom_range(0, 15));
            end
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4) && (fid != '0),
                 fid, ($urandom_range(0, 31) == 0));
         end
      end
      step(1'b0, 1'b0, 4'b0000, 1'b0);

      @(negedge clk); #1;
      n_vec++;
      if (q.size() != 0) begin
         n_miss++;
         $display("FAIL queue_drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
